// File: rtl/mem_stage_pkg.sv
// Shared encodings for the M-stage data-memory access path.
package mem_stage_pkg;

  localparam logic [1:0] BC_WORD = 2'b00;
  localparam logic [1:0] BC_HALF = 2'b01;
  localparam logic [1:0] BC_BYTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mem_state_e;

  // Load shape captured at issue so extraction does not depend on EX/MEM holding still
  typedef struct packed {
    logic       ld;
    logic       uns;
    logic [1:0] bc;
    logic [1:0] off;
  } ld_ctrl_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus; master is the M stage, slave is the memory.
interface mem_access_stage_if #(
  parameter int WIDTH = 32
) ();

  logic             dmem_req;
  logic             dmem_we;
  logic [WIDTH-1:0] dmem_addr;
  logic [3:0]       dmem_be;
  logic [WIDTH-1:0] dmem_wdata;
  logic             dmem_ack;
  logic [WIDTH-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: enables, store replication, load extract/extend, misalign check.
// Zero latency, no flow control.
module mem_lane_align
  import mem_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       bc,
  input  logic [1:0]       addr_lo,
  input  logic [WIDTH-1:0] wd,
  input  logic [1:0]       ld_bc,
  input  logic [1:0]       ld_off,
  input  logic             ld_uns,
  input  logic [WIDTH-1:0] rdata,
  output logic [3:0]       be,
  output logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] ld_data,
  output logic             misaligned
);

  logic [WIDTH-1:0] lane;

  always_comb begin
    be         = 4'b1111;
    wdata      = wd;
    misaligned = 1'b0;
    case (bc)
      BC_HALF: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{wd[15:0]}};
        misaligned = addr_lo[0];
      end
      BC_BYTE: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{wd[7:0]}};
      end
      // 2'b11 is decoded as a word access
      default: begin
        be         = 4'b1111;
        misaligned = |addr_lo;
      end
    endcase
  end

  assign lane = rdata >> {ld_off, 3'b000};

  always_comb begin
    ld_data = lane;
    case (ld_bc)
      BC_HALF: ld_data = {{16{~ld_uns & lane[15]}}, lane[15:0]};
      BC_BYTE: ld_data = {{24{~ld_uns & lane[7]}}, lane[7:0]};
      default: ld_data = lane;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS M stage: issues one req/ack data-memory access per instruction, stalls upstream until done.
// Latency >= 3 cycles (IDLE, BUSY, DONE); holds DONE until advance_M, bounded BUSY via timeout.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TCNT_W         = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                MemtoReg_M,
  input  logic                MemWrite_M,
  input  logic [1:0]          ByteControl_M,
  input  logic                LoadUnsigned_M,
  input  logic [WIDTH-1:0]    ALU_result_M,
  input  logic [WIDTH-1:0]    WriteData_M,
  input  logic                advance_M,
  mem_access_stage_if.master  dmem,
  output logic [WIDTH-1:0]    ReadData_M,
  output logic                stall_M,
  output logic                misalign_M,
  output logic                bus_error_M
);

  mem_state_e        state_q, state_d;
  ld_ctrl_t          ld_q;
  logic [TCNT_W-1:0] tcnt_q, tcnt_inc;
  logic              access, timeout_hit;
  logic [3:0]        be_c;
  logic [WIDTH-1:0]  wdata_c, ld_data_c;
  logic              misaligned_c;

  assign access      = MemtoReg_M | MemWrite_M;
  assign tcnt_inc    = tcnt_q + TCNT_W'(1);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt_inc == TCNT_W'(TIMEOUT_CYCLES));

  mem_lane_align #(.WIDTH(WIDTH)) u_lane (
    .bc         (ByteControl_M),
    .addr_lo    (ALU_result_M[1:0]),
    .wd         (WriteData_M),
    .ld_bc      (ld_q.bc),
    .ld_off     (ld_q.off),
    .ld_uns     (ld_q.uns),
    .rdata      (dmem.dmem_rdata),
    .be         (be_c),
    .wdata      (wdata_c),
    .ld_data    (ld_data_c),
    .misaligned (misaligned_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    stall_M    = 1'b0;
    misalign_M = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (misaligned_c) begin
            misalign_M = 1'b1;
          end else begin
            stall_M = 1'b1;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        stall_M = 1'b1;
        if (dmem.dmem_ack || timeout_hit) state_d = ST_DONE;
      end
      // No path back to BUSY from here, so a held store can never be replayed
      ST_DONE: if (advance_M) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (!rst_n) begin
      stall_M    = 1'b0;
      misalign_M = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_be    <= '0;
      dmem.dmem_wdata <= '0;
      ReadData_M      <= '0;
      bus_error_M     <= 1'b0;
      tcnt_q          <= '0;
      ld_q            <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (access && !misaligned_c) begin
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= MemWrite_M;
            dmem.dmem_addr  <= {ALU_result_M[WIDTH-1:2], 2'b00};
            dmem.dmem_be    <= be_c;
            dmem.dmem_wdata <= wdata_c;
            tcnt_q          <= '0;
            ld_q            <= '{ld:  MemtoReg_M & ~MemWrite_M,
                                 uns: LoadUnsigned_M,
                                 bc:  ByteControl_M,
                                 off: ALU_result_M[1:0]};
          end
        end
        ST_BUSY: begin
          tcnt_q <= tcnt_inc;
          if (dmem.dmem_ack) begin
            dmem.dmem_req <= 1'b0;
            dmem.dmem_we  <= 1'b0;
            if (ld_q.ld) ReadData_M <= ld_data_c;
          end else if (timeout_hit) begin
            dmem.dmem_req <= 1'b0;
            dmem.dmem_we  <= 1'b0;
            ReadData_M    <= '0;
            bus_error_M   <= 1'b1;
          end
        end
        ST_DONE: if (advance_M) bus_error_M <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed scoreboard bench for mem_access_stage with a delayed-ack memory responder.
module tb_mem_access_stage;
  import mem_stage_pkg::*;

  localparam int TO = 4;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } done_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemtoReg_M, MemWrite_M, LoadUnsigned_M, advance_M;
  logic [1:0]  ByteControl_M;
  logic [31:0] ALU_result_M, WriteData_M;
  logic [31:0] ReadData_M;
  logic        stall_M, misalign_M, bus_error_M;

  mem_access_stage_if #(.WIDTH(32)) bus ();

  mem_access_stage #(.WIDTH(32), .TIMEOUT_CYCLES(TO), .TCNT_W(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .MemtoReg_M     (MemtoReg_M),
    .MemWrite_M     (MemWrite_M),
    .ByteControl_M  (ByteControl_M),
    .LoadUnsigned_M (LoadUnsigned_M),
    .ALU_result_M   (ALU_result_M),
    .WriteData_M    (WriteData_M),
    .advance_M      (advance_M),
    .dmem           (bus.master),
    .ReadData_M     (ReadData_M),
    .stall_M        (stall_M),
    .misalign_M     (misalign_M),
    .bus_error_M    (bus_error_M)
  );

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_err = 0;
  int    n_req_exp = 0;
  int    n_req_seen = 0;
  req_t  exp_req_q[$];
  done_t exp_done_q[$];
  int    ack_delay = -1;
  logic [31:0] rsp_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory model: acks the ack_delay-th cycle it sees a request (never if negative)
  initial begin
    int cnt;
    cnt = 0;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.dmem_req) begin
        cnt++;
        if (cnt == ack_delay) begin
          bus.dmem_ack   = 1'b1;
          bus.dmem_rdata = rsp_rdata;
        end else begin
          bus.dmem_ack = 1'b0;
        end
      end else begin
        cnt = 0;
        bus.dmem_ack = 1'b0;
      end
    end
  end

  // Scoreboard monitor: request launch and request completion
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (bus.dmem_req === 1'b1 && !prev_req) begin
      req_t e;
      n_req_seen++;
      if (exp_req_q.size() == 0) begin
        check("unexpected_req", 32'(bus.dmem_req), 32'd0);
      end else begin
        e = exp_req_q.pop_front();
        check("req_we", 32'(bus.dmem_we), 32'(e.we));
        check("req_addr", bus.dmem_addr, e.addr);
        check("req_be", 32'(bus.dmem_be), 32'(e.be));
        check("req_wdata", bus.dmem_wdata, e.wdata);
      end
    end
    if (prev_req && bus.dmem_req === 1'b0 && rst_n) begin
      done_t d;
      if (exp_done_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        d = exp_done_q.pop_front();
        check("done_rdata", ReadData_M, d.rd);
        check("done_bus_error", 32'(bus_error_M), 32'(d.err));
      end
    end
    prev_req <= (bus.dmem_req === 1'b1);
  end

  task automatic clear_inputs();
    MemtoReg_M = 0; MemWrite_M = 0; ByteControl_M = 2'b00; LoadUnsigned_M = 0;
    ALU_result_M = '0; WriteData_M = '0; advance_M = 0;
  endtask

  task automatic run_access(input logic ld, input logic st, input logic [1:0] bc,
                            input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rdata, input int delay, input logic [3:0] ebe,
                            input logic [31:0] ewdata, input logic [31:0] erd,
                            input logic eerr, input int hold);
    int n;
    exp_req_q.push_back('{we: st, addr: addr & 32'hFFFF_FFFC, be: ebe, wdata: ewdata});
    exp_done_q.push_back('{rd: erd, err: eerr});
    n_req_exp++;
    ack_delay = delay;
    rsp_rdata = rdata;
    @(negedge clk);
    MemtoReg_M = ld; MemWrite_M = st; ByteControl_M = bc; LoadUnsigned_M = uns;
    ALU_result_M = addr; WriteData_M = wd; advance_M = 0;
    #1;
    check("misalign_aligned", 32'(misalign_M), 32'd0);
    n = 0;
    while (stall_M && n < 50) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("stall_cycles", 32'(n), 32'(delay < 0 ? 1 + TO : 1 + delay));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      check("done_hold_rdata", ReadData_M, erd);
      check("done_hold_req", 32'(bus.dmem_req), 32'd0);
      check("done_hold_stall", 32'(stall_M), 32'd0);
      check("done_hold_err", 32'(bus_error_M), 32'(eerr));
    end
    @(negedge clk);
    advance_M = 1;
    @(negedge clk);
    clear_inputs();
    #1;
    check("post_advance_err", 32'(bus_error_M), 32'd0);
    check("post_advance_stall", 32'(stall_M), 32'd0);
  endtask

  task automatic run_misalign(input logic [1:0] bc, input logic [31:0] addr);
    @(negedge clk);
    MemtoReg_M = 1; ByteControl_M = bc; ALU_result_M = addr;
    #1;
    check("misalign_flag", 32'(misalign_M), 32'd1);
    check("misalign_stall", 32'(stall_M), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("misalign_no_req", 32'(bus.dmem_req), 32'd0);
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst_n = 0;
    // Misaligned access presented during reset must not raise misalign or stall
    MemtoReg_M = 1; ALU_result_M = 32'h6;
    repeat (2) @(negedge clk);
    #1;
    check("rst_misalign", 32'(misalign_M), 32'd0);
    check("rst_stall", 32'(stall_M), 32'd0);
    check("rst_req", 32'(bus.dmem_req), 32'd0);
    check("rst_rdata", ReadData_M, 32'd0);
    check("rst_err", 32'(bus_error_M), 32'd0);
    clear_inputs();
    @(negedge clk);
    rst_n = 1;

    run_access(0, 1, BC_WORD, 0, 32'h10, 32'hDEADBEEF, 32'h0,       2, 4'b1111, 32'hDEADBEEF, 32'h0,        0, 3);
    run_access(1, 0, BC_BYTE, 0, 32'h13, 32'h0,       32'h80112233, 1, 4'b1000, 32'h0,        32'hFFFFFF80, 0, 3);
    run_access(1, 0, BC_BYTE, 1, 32'h13, 32'h0,       32'h80112233, 3, 4'b1000, 32'h0,        32'h00000080, 0, 0);
    run_access(0, 1, BC_HALF, 0, 32'h22, 32'h0000ABCD, 32'h0,       1, 4'b1100, 32'hABCDABCD, 32'h00000080, 0, 1);
    run_misalign(BC_WORD, 32'h06);
    run_access(1, 0, BC_HALF, 0, 32'h02, 32'h0,       32'h80017F00, 1, 4'b1100, 32'h0,        32'hFFFF8001, 0, 0);
    run_access(1, 0, BC_HALF, 1, 32'h00, 32'h0,       32'h12348765, 2, 4'b0011, 32'h0,        32'h00008765, 0, 0);
    run_access(1, 0, 2'b11,   0, 32'h44, 32'h0,       32'hCAFEF00D, 1, 4'b1111, 32'h0,        32'hCAFEF00D, 0, 0);
    run_access(0, 1, BC_BYTE, 0, 32'h31, 32'h123456A5, 32'h0,       1, 4'b0010, 32'hA5A5A5A5, 32'hCAFEF00D, 0, 0);
    run_access(1, 1, BC_WORD, 0, 32'h50, 32'h11112222, 32'h99,      1, 4'b1111, 32'h11112222, 32'hCAFEF00D, 0, 0);
    run_misalign(BC_HALF, 32'h01);
    run_access(1, 0, BC_WORD, 0, 32'h60, 32'h0,       32'h0,       -1, 4'b1111, 32'h0,        32'h0,        1, 2);

    // Reset while BUSY: the outstanding request is abandoned
    exp_req_q.push_back('{we: 1'b0, addr: 32'h80, be: 4'b1111, wdata: 32'h0});
    n_req_exp++;
    ack_delay = -1;
    @(negedge clk);
    MemtoReg_M = 1; ALU_result_M = 32'h80; ByteControl_M = BC_WORD;
    repeat (2) @(negedge clk);
    #1;
    check("midbusy_req", 32'(bus.dmem_req), 32'd1);
    rst_n = 0;
    #1;
    check("midbusy_rst_stall", 32'(stall_M), 32'd0);
    @(negedge clk);
    #1;
    check("midbusy_req_drop", 32'(bus.dmem_req), 32'd0);
    check("midbusy_we", 32'(bus.dmem_we), 32'd0);
    check("midbusy_addr", bus.dmem_addr, 32'd0);
    check("midbusy_be", 32'(bus.dmem_be), 32'd0);
    check("midbusy_wdata", bus.dmem_wdata, 32'd0);
    check("midbusy_rdata", ReadData_M, 32'd0);
    check("midbusy_err", 32'(bus_error_M), 32'd0);
    check("midbusy_state", 32'(dut.state_q), 32'(ST_IDLE));
    clear_inputs();
    @(negedge clk);
    rst_n = 1;

    run_access(1, 0, BC_WORD, 0, 32'h70, 32'h0, 32'h01234567, 1, 4'b1111, 32'h0, 32'h01234567, 0, 0);

    repeat (3) @(negedge clk);
    check("req_count", 32'(n_req_seen), 32'(n_req_exp));
    check("req_queue_empty", 32'(exp_req_q.size()), 32'd0);
    check("done_queue_empty", 32'(exp_done_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory (M) stage of the 5-stage MIPS pipeline. Sits directly downstream of the EX/MEM pipeline register and consumes ALU_result_M, WriteData_M, ByteControl_M, MemWrite_M and MemtoReg_M.
- Runs word, halfword and byte loads and stores over a req/ack data-memory bus. Generates byte enables, store-lane replication, and load extraction with sign or zero extension.
- Raises stall_M to the hazard unit while an access is outstanding, and flags misaligned accesses and bus timeouts.

Parameters:
- WIDTH_32, 32, data/address width.
- TIMEOUT_CYCLES, 16, maximum BUSY cycles without dmem_ack before bus error. 0 disables the timeout.
- TCNT_W, 5, timeout counter width. Must satisfy 2^TCNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- MemtoReg_M  in  1  load instruction in M.
- MemWrite_M  in  1  store instruction in M.
- ByteControl_M  in  2  access size: 00 word, 01 half, 10 byte, 11 treated as word.
- LoadUnsigned_M  in  1  1 = zero-extend loads, 0 = sign-extend loads.
- ALU_result_M  in  32  effective byte address.
- WriteData_M  in  32  store data, right-justified.
- advance_M  in  1  MEM/WB register enable this cycle; the pipeline is leaving M.
- dmem_req  out  1  bus request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word-aligned address, bits [1:0] = 0.
- dmem_be  out  4  byte enables, little-endian.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  bus completion. Valid only while dmem_req = 1.
- dmem_rdata  in  32  read word, valid with dmem_ack.
- ReadData_M  out  32  extended load result. Held stable through DONE.
- stall_M  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- misalign_M  out  1  misaligned access detected.
- bus_error_M  out  1  timeout occurred on this access.

Behaviour:
- Reset (rst_n = 0 at posedge):
  - State goes to IDLE.
  - dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, ReadData_M and bus_error_M all clear to 0.
  - Timeout counter clears to 0.
  - stall_M and misalign_M are forced to 0 while rst_n = 0.
  - Reset mid-BUSY drops dmem_req on that edge. The memory must abandon the transaction.
- Access and alignment:
  - An access exists when MemtoReg_M | MemWrite_M.
  - If both are set, the access is treated as a store and ReadData_M is not updated.
  - Misaligned means: half with addr[0] = 1, or word with addr[1:0] != 0.
  - misalign_M is combinational: set in IDLE when the access is misaligned.
  - A misaligned access issues no request, does not stall and performs no write.
- FSM IDLE -> BUSY -> DONE -> IDLE.
  - IDLE: an aligned access asserts stall_M combinationally. At the next edge:
    - dmem_req = 1.
    - dmem_we = MemWrite_M.
    - dmem_addr = {addr[31:2], 2'b00}.
    - dmem_be and dmem_wdata are latched.
    - State goes to BUSY.
  - BUSY: stall_M = 1. The counter increments each cycle.
    - On dmem_ack: drop dmem_req and dmem_we. For loads, capture the extended load into ReadData_M. Go to DONE.
    - On the counter reaching TIMEOUT_CYCLES (when non-zero) with no ack: drop dmem_req, set ReadData_M = 0, set bus_error_M = 1, go to DONE.
    - If ack and timeout coincide, ack wins.
  - DONE: stall_M = 0.
    - If advance_M: go to IDLE and clear bus_error_M.
    - Otherwise hold DONE. There is no re-issue, which guarantees no duplicate store.
  - Minimum latency is 3 cycles with ack in the first BUSY cycle: IDLE, BUSY, DONE.
- Byte enables:
  - word: 1111.
  - half: addr[1] = 0 gives 0011, addr[1] = 1 gives 1100.
  - byte: 0001 << addr[1:0].
- Store data:
  - byte: {4{wd[7:0]}}.
  - half: {2{wd[15:0]}}.
  - word: wd.
- Load extraction:
  - lane = dmem_rdata >> (8 * addr[1:0]).
  - byte uses lane[7:0]; half uses lane[15:0]. Each is sign- or zero-extended per LoadUnsigned_M.
  - word loads pass the full 32 bits.

Decomposition:
- Shared package mem_stage_pkg holds:
  - ByteControl encodings BC_WORD = 2'b00, BC_HALF = 2'b01, BC_BYTE = 2'b10.
  - State encoding for IDLE, BUSY, DONE.
- Sub-module mem_lane_align (combinational) holds byte-enable generation, store replication, load extraction/extension and the misalign check.
- The top level holds the FSM, timeout counter and registered outputs.

Test Plan:
- Word store: addr 0x10, data 0xDEADBEEF, ack 2 cycles after req -> dmem_we = 1, be = 1111, wdata = 0xDEADBEEF, addr = 0x10; stall_M high for 3 cycles; one request only.
- Signed byte load: addr 0x13, rdata 0x80112233 -> be = 1000, ReadData_M = 0xFFFFFF80. Unsigned variant -> 0x00000080.
- Half store: addr 0x22, data 0x0000ABCD -> be = 1100, wdata = 0xABCDABCD, dmem_addr = 0x20.
- Misaligned word load: addr 0x06 -> misalign_M = 1, stall_M = 0, dmem_req never asserts.
- Timeout with TIMEOUT_CYCLES = 4 and no ack -> req drops after 4 BUSY cycles, bus_error_M = 1, ReadData_M = 0, stall_M falls.
- advance_M held low 3 cycles in DONE -> state stays DONE, no second req, ReadData_M stable.
- Reset mid-BUSY -> req = 0 after the edge, state IDLE, all outputs 0.
